keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and reading the four row lines.
- Synchronizes and debounces presses, then emits one hex code and a one-cycle strobe per press.
- Keeps a two-digit history (newest, previous) that feeds the existing dual seven-segment display multiplexer as its s0/s1 sources.
- Clocked from the HSOSC-derived system clock (24 MHz nominal).

Parameters:
- SCAN_DIV, 24000: clk cycles per column dwell (1 ms at 24 MHz); must be >= 4.
- DEBOUNCE_TICKS, 20: consecutive dwell ticks a press or release must be stable; must be >= 1.
- REPEAT_TICKS, 500: dwell ticks between auto-repeat strobes; used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rows  input  4  keypad row lines, active-low (external pull-ups), asynchronous to clk
- cols  output  4  keypad column drives, active-low, exactly one bit low at all times
- key_code  output  4  hex value of the last accepted key
- key_valid  output  1  one-cycle strobe when key_code updates
- key_held  output  1  high while an accepted key remains pressed
- digit_new  output  4  most recent accepted key
- digit_old  output  4  key accepted before digit_new

Behaviour:
- Reset is asynchronous, active-low, and clock is clk.
- Reset values: cols=4'b1110, key_code=0, key_valid=0, key_held=0, digit_new=0, digit_old=0, state=SCAN, all counters 0, synchronizer flops 4'b1111.
- rows pass through a 2-flop synchronizer (rows_s). All decisions use rows_s.
- Tick: the dwell counter runs 0..SCAN_DIV-1. A tick is the cycle the counter equals SCAN_DIV-1. rows_s is sampled only on ticks.
- Key map (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D. c0 is cols[0].
- A sample is "single" when exactly one bit of rows_s is low.
- SCAN:
  - On each tick, if the sample is single, capture row/col and go to DEBOUNCE; the column stays frozen.
  - Otherwise rotate cols 1110->1101->1011->0111->1110.
  - Zero rows low or two or more rows low (ghosting/multi-press) is ignored.
- DEBOUNCE: on each tick, if the sample is single and equals the captured row, increment the counter; otherwise clear it, rotate the column and return to SCAN.
  - When the counter reaches DEBOUNCE_TICKS, in one cycle:
    - key_valid=1
    - key_code=mapped code
    - digit_old<=digit_new
    - digit_new<=code
    - key_held=1
    - go to HELD
  - Latency from the first stable tick to the strobe is DEBOUNCE_TICKS ticks.
- HELD: the column stays frozen. Other keys are ignored, including extra rows low on the same column. When the captured row reads high on a tick, go to RELEASE with the counter at 1.
- RELEASE:
  - Captured row high on a tick: increment the counter.
  - Captured row low: return to HELD; no new strobe.
  - Counter reaches DEBOUNCE_TICKS: key_held=0, rotate to the next column, go to SCAN.
  - A second key still held at that point is detected as a fresh press.
- key_valid is high for exactly one clk cycle per accepted event and never in consecutive cycles.
- Reset asserted in any state returns all outputs to their reset values immediately. No strobe is produced on reset release.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks. Each time it reaches REPEAT_TICKS, the block pulses key_valid for one cycle with the same key_code, shifts digit_old<=digit_new, digit_new<=code, and clears the counter. The counter also clears on entering HELD.
- Undefined: no repeat counter exists and there is exactly one strobe per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5):
- Reset, rows=1111 -> cols=1110 and all outputs 0; cols step 1110->1101->1011->0111->1110 every 4 cycles.
- Hold rows=1101 whenever cols=1101 (key 5) -> after 3 stable ticks: key_valid pulses once, key_code=5, digit_new=5, digit_old=0, key_held=1, cols frozen at 1101.
- Key 5 press bouncing (high on the 2nd tick) -> no key_valid; scanning resumes at 1011.
- Press/release 1 then D -> two strobes; digit_new=D, digit_old=1; key_held=0 after each release debounce.
- rows=1100 while cols=1110 -> no strobe, scanning continues; reset mid-HELD -> cols=1110, digits 0, key_held 0 at once.
- KEY_REPEAT_EN defined, key 5 held for 12 ticks after acceptance -> 3 strobes total, digit_new=5, digit_old=5; undefined -> 1 strobe.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : 4x4 matrix keypad scanner. Drives one column low at a time,
//             synchronizes and debounces the row lines, and emits one hex
//             code plus a one-cycle strobe per accepted press. Keeps a
//             two-digit history (digit_new / digit_old) for the display mux.
//  Options  : KEY_REPEAT_EN - when defined, a held key re-strobes every
//             REPEAT_TICKS dwell ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
   parameter int SCAN_DIV       = 24000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_TICKS   = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int c_DIV_W = $clog2(SCAN_DIV);
   localparam int c_DB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_DB_W-1:0]  c_DB_MAX   = c_DB_W'(DEBOUNCE_TICKS);
   localparam bit                 c_DB_ONE   = (DEBOUNCE_TICKS == 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Out-of-range parameters are rejected at elaboration.
   if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   logic [3:0]         r_rows_m, r_rows_s;
   logic [c_DIV_W-1:0] r_div;
   state_t             r_state, w_state_nxt;
   logic [c_DB_W-1:0]  r_db_cnt, w_db_nxt, w_db_inc;
   logic [1:0]         r_row, w_row_nxt, r_col, w_col_nxt;
   logic [1:0]         w_row_idx, w_cap_row;
   logic [3:0]         w_low, w_code;
   logic               w_tick, w_single, w_row_high;
   logic               w_accept, w_release_done, w_repeat;
   logic [3:0]         r_key_code, r_digit_new, r_digit_old;
   logic               r_key_valid, r_key_held;

`ifdef KEY_REPEAT_EN
   localparam int c_REP_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(REPEAT_TICKS);
   logic [c_REP_W-1:0] r_rep_cnt, w_rep_nxt, w_rep_inc;
   assign w_rep_inc = r_rep_cnt + c_REP_W'(1);
`endif

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'h0;
      case ({row, col})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      endcase
      return code;
   endfunction

   assign w_tick     = (r_div == c_DIV_LAST);
   assign w_low      = ~r_rows_s;
   assign w_single   = (w_low != 4'b0000) && ((w_low & (w_low - 4'b0001)) == 4'b0000);
   assign w_row_high = r_rows_s[r_row];
   assign w_db_inc   = r_db_cnt + c_DB_W'(1);
   assign w_cap_row  = (r_state == ST_SCAN) ? w_row_idx : r_row;
   assign w_code     = key_map(w_cap_row, r_col);

   // Two-flop synchronizer for the asynchronous row lines, plus dwell divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rows_m <= 4'b1111;
         r_rows_s <= 4'b1111;
         r_div    <= '0;
      end else begin
         r_rows_m <= rows;
         r_rows_s <= r_rows_m;
         r_div    <= w_tick ? '0 : r_div + c_DIV_W'(1);
      end
   end

   // Index of the lowest low row bit; only meaningful when the sample is single.
   always_comb begin
      w_row_idx = 2'd0;
      if      (!r_rows_s[0]) w_row_idx = 2'd0;
      else if (!r_rows_s[1]) w_row_idx = 2'd1;
      else if (!r_rows_s[2]) w_row_idx = 2'd2;
      else if (!r_rows_s[3]) w_row_idx = 2'd3;
   end

   // FSM state and scan bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_SCAN;
         r_db_cnt <= '0;
         r_row    <= 2'd0;
         r_col    <= 2'd0;
`ifdef KEY_REPEAT_EN
         r_rep_cnt <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_db_cnt <= w_db_nxt;
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
`ifdef KEY_REPEAT_EN
         r_rep_cnt <= w_rep_nxt;
`endif
      end
   end

   // Next-state logic; all decisions are taken on dwell ticks only.
   always_comb begin
      w_state_nxt    = r_state;
      w_db_nxt       = r_db_cnt;
      w_row_nxt      = r_row;
      w_col_nxt      = r_col;
      w_accept       = 1'b0;
      w_release_done = 1'b0;
      w_repeat       = 1'b0;
`ifdef KEY_REPEAT_EN
      w_rep_nxt      = r_rep_cnt;
`endif
      case (r_state)
         ST_SCAN: begin
            if (w_tick) begin
               if (w_single) begin
                  // The capture tick counts as the first stable sample.
                  w_row_nxt = w_row_idx;
                  if (c_DB_ONE) begin
                     w_accept = 1'b1;
                  end else begin
                     w_state_nxt = ST_DEBOUNCE;
                     w_db_nxt    = c_DB_W'(1);
                  end
               end else begin
                  w_col_nxt = r_col + 2'd1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (w_tick) begin
               if (w_single && (w_row_idx == r_row)) begin
                  if (w_db_inc == c_DB_MAX) w_accept = 1'b1;
                  else                      w_db_nxt = w_db_inc;
               end else begin
                  w_db_nxt    = '0;
                  w_col_nxt   = r_col + 2'd1;
                  w_state_nxt = ST_SCAN;
               end
            end
         end
         ST_HELD: begin
            // Only the captured row matters; other rows on this column are ignored.
            if (w_tick) begin
               if (w_row_high) begin
                  if (c_DB_ONE) begin
                     w_release_done = 1'b1;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                     w_db_nxt    = c_DB_W'(1);
                  end
               end
`ifdef KEY_REPEAT_EN
               else if (w_rep_inc == c_REP_MAX) begin
                  w_repeat  = 1'b1;
                  w_rep_nxt = '0;
               end else begin
                  w_rep_nxt = w_rep_inc;
               end
`endif
            end
         end
         ST_RELEASE: begin
            if (w_tick) begin
               if (w_row_high) begin
                  if (w_db_inc == c_DB_MAX) w_release_done = 1'b1;
                  else                      w_db_nxt = w_db_inc;
               end else begin
                  w_state_nxt = ST_HELD;
                  w_db_nxt    = '0;
`ifdef KEY_REPEAT_EN
                  w_rep_nxt   = '0;
`endif
               end
            end
         end
         default: w_state_nxt = ST_SCAN;
      endcase

      if (w_accept) begin
         w_state_nxt = ST_HELD;
         w_db_nxt    = '0;
`ifdef KEY_REPEAT_EN
         w_rep_nxt   = '0;
`endif
      end
      if (w_release_done) begin
         w_state_nxt = ST_SCAN;
         w_db_nxt    = '0;
         w_col_nxt   = r_col + 2'd1;
      end
   end

   // Key output registers and the two-digit history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_digit_new <= 4'h0;
         r_digit_old <= 4'h0;
      end else begin
         r_key_valid <= w_accept | w_repeat;
         if (w_accept | w_repeat) begin
            r_key_code  <= w_code;
            r_digit_old <= r_digit_new;
            r_digit_new <= w_code;
         end
         if (w_accept)            r_key_held <= 1'b1;
         else if (w_release_done) r_key_held <= 1'b0;
      end
   end

   assign cols      = 4'b1111 ^ (4'b0001 << r_col);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign digit_new = r_digit_new;
   assign digit_old = r_digit_old;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Directed self-checking bench for keypad_scanner with
//             SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5. A behavioural
//             key drives one row pattern whenever its column is selected.
//  Options  : KEY_REPEAT_EN selects the auto-repeat expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] rows, cols, key_code, digit_new, digit_old;
   logic       key_valid, key_held;

   logic       press_en = 1'b0;
   logic       force_high = 1'b0;
   logic [3:0] key_rowpat = 4'hF;
   logic [3:0] key_colpat = 4'hF;

   int   total = 0;
   int   bad = 0;
   int   n_strobes = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;
   logic saw_double = 1'b0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
      .clk(clk), .reset(reset), .rows(rows), .cols(cols),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .digit_new(digit_new), .digit_old(digit_old)
   );

   always #5 clk = ~clk;

   // Simulated keypad: the pressed key pulls its row low while its column is driven.
   assign rows = (press_en && !force_high && cols == key_colpat) ? key_rowpat : 4'hF;

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc++;

   // Strobe monitor: counts strobes and flags back-to-back strobes.
   always @(negedge clk) begin
      if (key_valid === 1'b1) n_strobes++;
      if (key_valid === 1'b1 && prev_valid === 1'b1) saw_double = 1'b1;
      prev_valid = key_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic press(input logic [3:0] rowpat, input logic [3:0] colpat);
      key_rowpat = rowpat;
      key_colpat = colpat;
      press_en   = 1'b1;
   endtask

   task automatic wait_cols(input logic [3:0] v, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cols === v) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_released(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      repeat (3) @(negedge clk);
      total++; if (cols !== 4'b1110) begin bad++; $display("FAIL rst_cols: got %b want %b", cols, 4'b1110); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst_code: got %h want 0", key_code); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", key_held); end
      total++; if (digit_new !== 4'h0) begin bad++; $display("FAIL rst_dnew: got %h want 0", digit_new); end
      total++; if (digit_old !== 4'h0) begin bad++; $display("FAIL rst_dold: got %h want 0", digit_old); end
      reset = 1'b1;
      // Column k/4 is selected after k rising edges since reset release.
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
         total++; if (cols !== exp) begin bad++; $display("FAIL scan_step%0d: got %b want %b", k, cols, exp); end
      end
   endtask

   task automatic test_key5();
      bit ok;
      int s, t0;
      s = n_strobes;
      press(4'b1101, 4'b1101);
      wait_cols(4'b1101, 40, ok);
      t0 = cyc;
      total++; if (!ok) begin bad++; $display("FAIL k5_col: got %b want 1101", cols); end
      wait_valid(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL k5_strobe: got none want strobe"); end
      total++; if (cyc - t0 !== 12) begin bad++; $display("FAIL k5_latency: got %0d want 12", cyc - t0); end
      total++; if (key_code !== 4'h5) begin bad++; $display("FAIL k5_code: got %h want 5", key_code); end
      total++; if (digit_new !== 4'h5) begin bad++; $display("FAIL k5_dnew: got %h want 5", digit_new); end
      total++; if (digit_old !== 4'h0) begin bad++; $display("FAIL k5_dold: got %h want 0", digit_old); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL k5_held: got %b want 1", key_held); end
      repeat (12) @(negedge clk);
      total++; if (cols !== 4'b1101) begin bad++; $display("FAIL k5_frozen: got %b want 1101", cols); end
      total++; if (n_strobes - s !== 1) begin bad++; $display("FAIL k5_count: got %0d want 1", n_strobes - s); end
      press_en = 1'b0;
      wait_released(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL k5_release: got held=%b want 0", key_held); end
      total++; if (cols !== 4'b1011) begin bad++; $display("FAIL k5_next_col: got %b want 1011", cols); end
      total++; if (n_strobes - s !== 1) begin bad++; $display("FAIL k5_count_rel: got %0d want 1", n_strobes - s); end
   endtask

   task automatic test_bounce();
      bit ok;
      int s;
      wait_cols(4'b1011, 40, ok);
      s = n_strobes;
      press(4'b1101, 4'b1101);
      wait_cols(4'b1101, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL bnc_col: got %b want 1101", cols); end
      repeat (4) @(negedge clk);
      force_high = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (cols !== 4'b1011) begin bad++; $display("FAIL bnc_resume: got %b want 1011", cols); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bnc_held: got %b want 0", key_held); end
      total++; if (n_strobes - s !== 0) begin bad++; $display("FAIL bnc_count: got %0d want 0", n_strobes - s); end
      press_en   = 1'b0;
      force_high = 1'b0;
   endtask

   task automatic test_two_keys();
      bit ok;
      int s;
      s = n_strobes;
      press(4'b1110, 4'b1110);
      wait_valid(200, ok);
      total++; if (key_code !== 4'h1) begin bad++; $display("FAIL k1_code: got %h want 1", key_code); end
      press_en = 1'b0;
      wait_released(200, ok);
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL k1_held: got %b want 0", key_held); end
      press(4'b0111, 4'b0111);
      wait_valid(200, ok);
      total++; if (key_code !== 4'hD) begin bad++; $display("FAIL kD_code: got %h want d", key_code); end
      press_en = 1'b0;
      wait_released(200, ok);
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL kD_held: got %b want 0", key_held); end
      total++; if (digit_new !== 4'hD) begin bad++; $display("FAIL two_dnew: got %h want d", digit_new); end
      total++; if (digit_old !== 4'h1) begin bad++; $display("FAIL two_dold: got %h want 1", digit_old); end
      total++; if (n_strobes - s !== 2) begin bad++; $display("FAIL two_count: got %0d want 2", n_strobes - s); end
   endtask

   task automatic test_ghost();
      bit ok;
      int s;
      s = n_strobes;
      press(4'b1100, 4'b1110);
      wait_cols(4'b0111, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL ghost_scan1: got %b want 0111", cols); end
      wait_cols(4'b1110, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL ghost_scan2: got %b want 1110", cols); end
      wait_cols(4'b1101, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL ghost_scan3: got %b want 1101", cols); end
      total++; if (n_strobes - s !== 0) begin bad++; $display("FAIL ghost_count: got %0d want 0", n_strobes - s); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held: got %b want 0", key_held); end
      press_en = 1'b0;
   endtask

   task automatic test_reset_held();
      bit ok;
      int s;
      press(4'b1101, 4'b1101);
      wait_valid(100, ok);
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL rh_held_pre: got %b want 1", key_held); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (cols !== 4'b1110) begin bad++; $display("FAIL rh_cols: got %b want 1110", cols); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rh_held: got %b want 0", key_held); end
      total++; if (digit_new !== 4'h0) begin bad++; $display("FAIL rh_dnew: got %h want 0", digit_new); end
      total++; if (digit_old !== 4'h0) begin bad++; $display("FAIL rh_dold: got %h want 0", digit_old); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rh_code: got %h want 0", key_code); end
      press_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      s = n_strobes;
      repeat (12) @(negedge clk);
      total++; if (n_strobes - s !== 0) begin bad++; $display("FAIL rh_no_strobe: got %0d want 0", n_strobes - s); end
   endtask

   task automatic test_repeat();
      bit ok;
      int s;
      int exp_n;
      logic [3:0] exp_old;
`ifdef KEY_REPEAT_EN
      exp_n   = 3;
      exp_old = 4'h5;
`else
      exp_n   = 1;
      exp_old = 4'h0;
`endif
      s = n_strobes;
      press(4'b1101, 4'b1101);
      wait_valid(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL rep_first: got none want strobe"); end
      repeat (48) @(negedge clk);
      press_en = 1'b0;
      wait_released(200, ok);
      repeat (2) @(negedge clk);
      total++; if (n_strobes - s !== exp_n) begin bad++; $display("FAIL rep_count: got %0d want %0d", n_strobes - s, exp_n); end
      total++; if (digit_new !== 4'h5) begin bad++; $display("FAIL rep_dnew: got %h want 5", digit_new); end
      total++; if (digit_old !== exp_old) begin bad++; $display("FAIL rep_dold: got %h want %h", digit_old, exp_old); end
      total++; if (key_code !== 4'h5) begin bad++; $display("FAIL rep_code: got %h want 5", key_code); end
   endtask

   task automatic test_strobe_width();
      total++; if (saw_double !== 1'b0) begin bad++; $display("FAIL strobe_width: got back-to-back want single-cycle"); end
   endtask

   initial begin
      test_reset();
      test_key5();
      test_bounce();
      test_two_keys();
      test_ghost();
      test_reset_held();
      test_repeat();
      test_strobe_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
